// File: rtl/mips16_pkg.sv
// Shared fetch-stage definitions: opcodes, NOP encoding, fetch state encoding
// and default bus widths for the mips16 pipeline.
package mips16_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_INS_W  = 32;

    localparam logic [5:0] OP_HLT = 6'b010001;
    localparam logic [5:0] OP_LD  = 6'b010100;
    localparam logic [5:0] OP_JMP = 6'b011110;

    localparam logic [DEF_INS_W-1:0] NOP_INS = '0;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_SQUASH,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Synchronous instruction-memory read port: address out, data back
// one cycle later.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = mips16_pkg::DEF_ADDR_W,
    parameter int INS_W  = mips16_pkg::DEF_INS_W
);

    logic [ADDR_W-1:0] imem_addr;
    logic [INS_W-1:0]  imem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_unit_skid.sv
// One-entry holding register for an instruction that came back from imem
// while the stage could not issue it.
module fetch_skid_buf #(
    parameter int ADDR_W = 16,
    parameter int INS_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [INS_W-1:0]  i_data,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_full,
    output logic [INS_W-1:0]  o_data,
    output logic [ADDR_W-1:0] o_addr
);

    logic              r_full;
    logic [INS_W-1:0]  r_data;
    logic [ADDR_W-1:0] r_addr;

    // load beats pop so a pop+load pair keeps the entry occupied
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_addr <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
            r_addr <= i_addr;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    a_no_overrun: assert property (
        @(posedge clk) disable iff (reset)
        !(i_load && r_full && !i_pop && !i_flush)
    );

    assign o_full = r_full;
    assign o_data = r_data;
    assign o_addr = r_addr;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives imem, issues instructions or bubbles
// under stall/stall_pm, squashes on redirect and parks on HLT.
module instr_fetch_unit
    import mips16_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INS_W  = DEF_INS_W
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master imem,
    input  logic               i_stall,
    input  logic               i_stall_pm,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [INS_W-1:0]   o_ins,
    output logic [5:0]         o_op,
    output logic               o_ins_valid
);

    localparam logic [INS_W-1:0] NOP = INS_W'(NOP_INS);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_infl;
    logic [ADDR_W-1:0] r_infl_addr;
    logic [ADDR_W-1:0] r_pc;
    logic [INS_W-1:0]  r_ins;
    logic              r_valid;

    logic              w_halt;
    logic              w_redir;
    logic              w_live;
    logic              w_ok;
    logic              w_sk_full;
    logic [INS_W-1:0]  w_sk_data;
    logic [ADDR_W-1:0] w_sk_addr;
    logic              w_pop;
    logic              w_take;
    logic              w_issue;
    logic              w_load;
    logic              w_fetch;
    logic [INS_W-1:0]  w_iss_data;
    logic [ADDR_W-1:0] w_iss_addr;
    logic              w_iss_hlt;

    assign w_halt  = (r_state == ST_HALT);
    assign w_redir = i_redirect && !w_halt;
    assign w_live  = !w_halt && !i_redirect;
    assign w_ok    = !i_stall && !i_stall_pm;

    // the skid entry is older than the in-flight word, so it goes first
    assign w_pop   = w_live && w_ok && w_sk_full;
    assign w_take  = w_live && w_ok && !w_sk_full && r_infl;
    assign w_issue = w_pop || w_take;
    assign w_load  = w_live && r_infl && !w_take;

    // with both skid and in-flight words pending, skip one fetch to drain
    assign w_fetch = w_live && !i_stall_pm && !(w_sk_full && r_infl);

    assign w_iss_data = w_sk_full ? w_sk_data : imem.imem_rdata;
    assign w_iss_addr = w_sk_full ? w_sk_addr : r_infl_addr;
    assign w_iss_hlt  = (w_iss_data[INS_W-1 -: 6] == OP_HLT);

    fetch_skid_buf #(
        .ADDR_W (ADDR_W),
        .INS_W  (INS_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_pop   (w_pop),
        .i_flush (w_redir),
        .i_data  (imem.imem_rdata),
        .i_addr  (r_infl_addr),
        .o_full  (w_sk_full),
        .o_data  (w_sk_data),
        .o_addr  (w_sk_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_fetch_pc  <= '0;
            r_infl      <= 1'b0;
            r_infl_addr <= '0;
            r_pc        <= '0;
            r_ins       <= NOP;
            r_valid     <= 1'b0;
        end else if (w_halt) begin
            r_infl  <= 1'b0;
            r_ins   <= NOP;
            r_valid <= 1'b0;
        end else if (i_redirect) begin
            r_state    <= ST_SQUASH;
            r_fetch_pc <= i_redirect_pc;
            r_infl     <= 1'b0;
            r_ins      <= NOP;
            r_valid    <= 1'b0;
        end else begin
            r_infl <= w_fetch;
            if (w_fetch) begin
                r_infl_addr <= r_fetch_pc;
                r_fetch_pc  <= r_fetch_pc + ADDR_W'(1);
            end
            r_ins   <= w_issue ? w_iss_data : NOP;
            r_valid <= w_issue;
            if (w_issue) begin
                r_pc <= w_iss_addr;
            end
            if (w_issue && w_iss_hlt) begin
                r_state <= ST_HALT;
            end else if (i_stall_pm) begin
                r_state <= ST_STALL;
            end else begin
                r_state <= ST_RUN;
            end
        end
    end

    assign imem.imem_addr = r_fetch_pc;
    assign o_pc           = r_pc;
    assign o_ins          = r_ins;
    assign o_op           = r_ins[INS_W-1 -: 6];
    assign o_ins_valid    = r_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit against an in-order
// issue-stream reference model.
module tb_instr_fetch_unit;
    import mips16_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st = 1'b0;
    logic        pm = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] rpc = '0;
    logic [15:0] o_pc;
    logic [31:0] o_ins;
    logic [5:0]  o_op;
    logic        o_v;
    logic        hlt3 = 1'b0;
    logic        rich = 1'b0;
    logic [31:0] mem_q;
    int          n_chk = 0;
    int          n_pass = 0;

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (bus),
        .i_stall       (st),
        .i_stall_pm    (pm),
        .i_redirect    (rd),
        .i_redirect_pc (rpc),
        .o_pc          (o_pc),
        .o_ins         (o_ins),
        .o_op          (o_op),
        .o_ins_valid   (o_v)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [15:0] a);
        if (hlt3 && a == 16'd3) return {OP_HLT, 26'b0};
        if (rich) return {(a[0] ? OP_LD : OP_JMP), 10'h155, a};
        return {16'h0, a} + 32'h100;
    endfunction

    always @(posedge clk) mem_q <= word(bus.imem_addr);
    assign bus.imem_rdata = mem_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic p, input logic r,
                         input logic [15:0] t);
        st = s;
        pm = p;
        rd = r;
        rpc = t;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_bubble(input string tag);
        chk(tag, 32'(o_v), 32'd0);
    endtask

    task automatic chk_issue(input string tag, input logic [15:0] a);
        logic [31:0] w;
        w = word(a);
        chk({tag, ".v"}, 32'(o_v), 32'd1);
        chk({tag, ".pc"}, 32'(o_pc), 32'(a));
        chk({tag, ".ins"}, o_ins, w);
        chk({tag, ".op"}, 32'(o_op), 32'(w[31:26]));
    endtask

    task automatic restart(input int upto);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        tick();
        reset = 1'b0;
        tick();
        chk_bubble("restart.lat");
        for (int i = 0; i <= upto; i++) begin
            tick();
            chk_issue("restart", 16'(i));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".v"}, 32'(o_v), 32'd0);
        chk({tag, ".ins"}, o_ins, 32'd0);
        chk({tag, ".pc"}, 32'(o_pc), 32'd0);
        chk({tag, ".op"}, 32'(o_op), 32'd0);
        chk({tag, ".addr"}, 32'(bus.imem_addr), 32'd0);
    endtask

    initial begin
        logic [15:0] exp;
        logic [15:0] t;
        logic        s;
        logic        p;
        logic        r;
        logic        sq;
        logic        ep_so;
        int          ep_pm;
        int          gap;
        int          issues;

        // straight-line fetch after a 2-cycle reset
        repeat (2) tick();
        chk_zero("rst");
        reset = 1'b0;
        tick();
        chk_bubble("t1.lat");
        tick();
        chk_issue("t1.first", 16'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_issue("t1.seq", 16'(i));
        end

        // stall + stall_pm for 3 cycles while pc=4 is on ins
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        repeat (3) begin
            tick();
            chk_bubble("t2.bub");
            chk("t2.addr", 32'(bus.imem_addr), 32'd6);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 5; i <= 7; i++) begin
            tick();
            chk_issue("t2.resume", 16'(i));
        end

        // stall_pm drops one cycle before stall
        restart(4);
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        repeat (2) begin
            tick();
            chk_bubble("t3.bub");
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        chk_bubble("t3.stall");
        chk("t3.addr", 32'(bus.imem_addr), 32'd7);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 5; i <= 7; i++) begin
            tick();
            chk_issue("t3.resume", 16'(i));
        end

        // redirect beats a simultaneous stall
        drive(1'b1, 1'b0, 1'b1, 16'h0040);
        tick();
        chk_bubble("t4.redir");
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        tick();
        chk_bubble("t4.squash");
        tick();
        chk_issue("t4.tgt", 16'h0040);
        tick();
        chk_issue("t4.next", 16'h0041);

        // PC wrap
        drive(1'b0, 1'b0, 1'b1, 16'hFFFE);
        tick();
        chk_bubble("t6.redir");
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        tick();
        chk_bubble("t6.squash");
        for (int k = 0; k < 4; k++) begin
            t = 16'hFFFE + 16'(k);
            tick();
            chk_issue("t6.wrap", t);
        end

        // reset while stalled with the skid entry full
        restart(4);
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk_zero("t7.rst");
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        tick();
        chk_bubble("t7.lat");
        for (int i = 0; i <= 2; i++) begin
            tick();
            chk_issue("t7.seq", 16'(i));
        end

        // HLT at address 3 parks the stage until reset
        hlt3 = 1'b1;
        restart(3);
        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom_range(0, 1));
            p = s & 1'($urandom_range(0, 1));
            drive(s, p, (i % 4) == 0, 16'($urandom));
            tick();
            chk_bubble("t5.halt");
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        reset = 1'b1;
        tick();
        chk_bubble("t5.rst");
        reset = 1'b0;
        tick();
        tick();
        chk_issue("t5.restart", 16'h0);

        // randomized stall episodes and redirects vs in-order stream model
        hlt3 = 1'b0;
        rich = 1'b1;
        restart(0);
        exp = 16'd1;
        sq = 1'b0;
        ep_so = 1'b0;
        ep_pm = 0;
        gap = 3;
        issues = 0;
        for (int c = 0; c < 400; c++) begin
            s = 1'b0;
            p = 1'b0;
            r = 1'b0;
            t = 16'h0;
            if (ep_pm > 0) begin
                s = 1'b1;
                p = 1'b1;
                ep_pm--;
                if (ep_pm == 0 && !ep_so) gap = 3;
            end else if (ep_so) begin
                s = 1'b1;
                ep_so = 1'b0;
                gap = 3;
            end else if (gap > 0) begin
                gap--;
            end else if (c < 390 && $urandom_range(0, 3) == 0) begin
                ep_pm = int'($urandom_range(0, 3));
                ep_so = (ep_pm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            if (!s && c < 390 && $urandom_range(0, 15) == 0) begin
                r = 1'b1;
                t = 16'($urandom);
            end
            drive(s, p, r, t);
            tick();
            if (r) begin
                chk_bubble("rnd.redir");
                exp = t;
                sq = 1'b1;
            end else if (sq) begin
                chk_bubble("rnd.squash");
                sq = 1'b0;
            end else if (s) begin
                chk_bubble("rnd.stall");
            end else if (o_v) begin
                chk_issue("rnd.issue", exp);
                exp++;
                issues++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_issue("rnd.drain", exp);
            exp++;
        end
        chk("rnd.progress", 32'(issues > 120), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
